// File: rtl/judge_pkg.sv
// rtl/judge_pkg.sv - shared types and helpers for the multi-slot character judge
package judge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_LOCKED = 2'd2
   } slot_state_e;

   function automatic logic [31:0] all_ones(input int unsigned w);
      return (32'h1 << w) - 32'h1;
   endfunction

   // Reserved class index meaning "no character decided"
   function automatic logic [31:0] EMPTY_IDX(input int unsigned idx_w);
      return all_ones(idx_w);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] mx;
      mx = all_ones(w);
      return (v >= mx) ? mx : v + 32'h1;
   endfunction

endpackage

// File: rtl/judge_slot.sv
// rtl/judge_slot.sv - one character position: run/majority accumulation and lock decision
module judge_slot
   import judge_pkg::*;
#(
   parameter int IDX_W  = 6,
   parameter int DIFF_W = 16,
   parameter int RUN_W  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              sample_valid,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DIFF_W-1:0] diff,
   input  logic [DIFF_W-1:0] max_diff,
   input  logic [RUN_W-1:0]  min_continue,
   input  logic [CNT_W-1:0]  min_counter,
   input  logic              all_done,
   output logic [IDX_W-1:0]  result,
   output logic              locked,
   output logic              forced,
   output logic              lock_next
);

   localparam logic [IDX_W-1:0] EMPTY = IDX_W'(EMPTY_IDX(IDX_W));

   slot_state_e       state_q, state_d;
   logic [IDX_W-1:0]  cand_q, cand_d;
   logic [CNT_W-1:0]  vote_q, vote_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic [IDX_W-1:0]  result_q, result_d;
   logic              forced_q, forced_d;
   logic [RUN_W-1:0]  run_min;

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      vote_d   = vote_q;
      last_d   = last_q;
      run_d    = run_q;
      total_d  = total_q;
      result_d = result_q;
      forced_d = forced_q;
      run_min  = (min_continue == '0) ? RUN_W'(1) : min_continue;

      if (state_q != ST_LOCKED) begin
         if (sample_valid) begin
            if (diff > max_diff) begin
               run_d = '0;
            end else begin
               total_d = CNT_W'(sat_inc(32'(total_q), CNT_W));
               if (idx == last_q && run_q != '0)
                  run_d = RUN_W'(sat_inc(32'(run_q), RUN_W));
               else
                  run_d = RUN_W'(1);
               last_d = idx;

               if (vote_q == '0) begin
                  cand_d = idx;
                  vote_d = CNT_W'(1);
               end else if (idx == cand_q) begin
                  vote_d = CNT_W'(sat_inc(32'(vote_q), CNT_W));
               end else begin
                  vote_d = vote_q - CNT_W'(1);
               end

               if (state_q == ST_IDLE)
                  state_d = ST_COUNT;

               // Run rule outranks the majority rule when both hit on one sample
               if (run_d >= run_min) begin
                  state_d  = ST_LOCKED;
                  result_d = idx;
                  forced_d = 1'b0;
               end else if (min_counter != '0 && total_d >= min_counter) begin
                  state_d  = ST_LOCKED;
                  result_d = (vote_d == '0) ? idx : cand_d;
                  forced_d = 1'b0;
               end
            end
         end

         if (state_d != ST_LOCKED && all_done) begin
            state_d  = ST_LOCKED;
            forced_d = 1'b1;
            result_d = (total_d != '0) ? cand_d : EMPTY;
         end
      end

      lock_next = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q  <= ST_IDLE;
         cand_q   <= '0;
         vote_q   <= '0;
         last_q   <= '0;
         run_q    <= '0;
         total_q  <= '0;
         result_q <= EMPTY;
         forced_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         vote_q   <= vote_d;
         last_q   <= last_d;
         run_q    <= run_d;
         total_q  <= total_d;
         result_q <= result_d;
         forced_q <= forced_d;
      end
   end

   assign result = result_q;
   assign locked = (state_q == ST_LOCKED);
   assign forced = forced_q;

endmodule

// File: rtl/judge_multi.sv
// rtl/judge_multi.sv - per-plate judge: slot decode, result packing, plate-done detection
module judge_multi
   import judge_pkg::*;
#(
   parameter int NUM_SLOTS = 7,
   parameter int SLOT_W    = 3,
   parameter int IDX_W     = 6,
   parameter int DIFF_W    = 16,
   parameter int RUN_W     = 4,
   parameter int CNT_W     = 8
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic                       clear,
   input  logic [SLOT_W-1:0]          char_slot,
   input  logic [IDX_W-1:0]           char_index,
   input  logic [DIFF_W-1:0]          char_diff,
   input  logic                       char_valid,
   input  logic [DIFF_W-1:0]          max_diff,
   input  logic [RUN_W-1:0]           min_continue,
   input  logic [CNT_W-1:0]           min_counter,
   input  logic                       all_done,
   output logic [NUM_SLOTS*IDX_W-1:0] char_index_o,
   output logic [NUM_SLOTS-1:0]       slot_locked,
   output logic [NUM_SLOTS-1:0]       slot_forced,
   output logic                       recognize_done,
   output logic                       done_pulse
);

   logic                 rst_any;
   logic [NUM_SLOTS-1:0] slot_valid;
   logic [NUM_SLOTS-1:0] lock_next;
   logic                 done_q, done_d;
   logic                 pulse_q, pulse_d;

   assign rst_any = srst | clear;

   // Out-of-range slot numbers match no decoder output and are dropped
   for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
      assign slot_valid[k] = char_valid && (char_slot == SLOT_W'(k));

      judge_slot #(
         .IDX_W  (IDX_W),
         .DIFF_W (DIFF_W),
         .RUN_W  (RUN_W),
         .CNT_W  (CNT_W)
      ) u_slot (
         .clk          (clk),
         .srst         (rst_any),
         .sample_valid (slot_valid[k]),
         .idx          (char_index),
         .diff         (char_diff),
         .max_diff     (max_diff),
         .min_continue (min_continue),
         .min_counter  (min_counter),
         .all_done     (all_done),
         .result       (char_index_o[k*IDX_W +: IDX_W]),
         .locked       (slot_locked[k]),
         .forced       (slot_forced[k]),
         .lock_next    (lock_next[k])
      );
   end

   always_comb begin
      done_d  = &lock_next;
      pulse_d = done_d & ~done_q;
   end

   always_ff @(posedge clk) begin
      if (rst_any) begin
         done_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         done_q  <= done_d;
         pulse_q <= pulse_d;
      end
   end

   assign recognize_done = done_q;
   assign done_pulse     = pulse_q;

endmodule

// File: doc/judge_multi.md
# judge_multi

Multi-slot, parametrised successor to the single-character judge. Recognition results for every character position of a plate arrive as (slot, index, diff) samples, one per frame per slot. The block accumulates them per slot and locks each slot by either of two paths: a consecutive-run rule or a Boyer-Moore majority vote once enough samples are seen. It sits between the template-matching engine and the ARM-visible result registers and signals when the whole plate is decided.

## Interface
- `NUM_SLOTS`, 7: character positions per plate.
- `SLOT_W`, 3: width of `char_slot`; must satisfy 2^SLOT_W ≥ NUM_SLOTS.
- `IDX_W`, 6: character class index width. All-ones is reserved as EMPTY.
- `DIFF_W`, 16: match-difference width.
- `RUN_W`, 4: consecutive-run counter width.
- `CNT_W`, 8: sample and vote counter width.

Ports:
- `clk`  in  1: clock.
- `srst`  in  1: synchronous active-high reset.
- `clear`  in  1: synchronous restart of all slots; same effect as `srst`.
- `char_slot`  in  SLOT_W: target slot of the sample.
- `char_index`  in  IDX_W: recognised class.
- `char_diff`  in  DIFF_W: match difference; lower is better.
- `char_valid`  in  1: one-cycle sample strobe.
- `max_diff`  in  DIFF_W: acceptance threshold.
- `min_continue`  in  RUN_W: run length that locks a slot.
- `min_counter`  in  CNT_W: accepted-sample count that locks a slot by majority; 0 disables this path.
- `all_done`  in  1: pulse, end of frame stream; forces decisions.
- `char_index_o`  out  NUM_SLOTS*IDX_W: per-slot result; slot k occupies bits [k*IDX_W +: IDX_W].
- `slot_locked`  out  NUM_SLOTS: slot decided.
- `slot_forced`  out  NUM_SLOTS: slot decided by `all_done` rather than a rule.
- `recognize_done`  out  1: level, all slots locked.
- `done_pulse`  out  1: one-cycle pulse on the rising edge of `recognize_done`.

## Operation
- Per-slot state machine: IDLE → COUNT on the first accepted sample. COUNT → LOCKED on a rule hit or on `all_done`. LOCKED holds until `srst`/`clear`.
- Per-slot registers:
  - `cand` (IDX_W) and `vote` (CNT_W): majority candidate.
  - `last` (IDX_W) and `run` (RUN_W): run tracking.
  - `total` (CNT_W): accepted-sample count.
- A sample applies only when `char_valid`, `char_slot` < NUM_SLOTS, and the slot is not LOCKED. Otherwise it is dropped silently.
- Rejected sample (`char_diff` > `max_diff`): `run` ← 0. No other register changes. `char_diff` == `max_diff` counts as accepted.
- Accepted sample:
  - `total` += 1, saturating.
  - Run update: if `idx` == `last` and `run` ≠ 0, `run` += 1 (saturating); otherwise `run` ← 1. Then `last` ← `idx`.
  - Vote update: if `vote` == 0, then `cand` ← `idx` and `vote` ← 1. Else if `idx` == `cand`, `vote` += 1 (saturating). Else `vote` -= 1.
- Lock rules, evaluated on the post-update values:
  - Run rule: `run` ≥ max(`min_continue`, 1) → result = `idx`. Has priority.
  - Count rule: `min_counter` ≠ 0 and `total` ≥ `min_counter` → result = `cand`. If `vote` == 0 after the update, result = `idx`.
- `all_done`: every unlocked slot locks in the same cycle with `slot_forced` = 1.
  - Result = `cand` if `total` > 0; otherwise EMPTY.
  - A sample arriving in the same cycle is applied first, then the force. A rule hit in that cycle wins and gives `slot_forced` = 0.
- `clear`/`srst` dominate `char_valid` and `all_done` in the same cycle.
- Reset values: all results = EMPTY (all ones); `slot_locked` = 0; `slot_forced` = 0; `recognize_done` = 0; `done_pulse` = 0; all counters 0; all states IDLE.

## Timing
- Every output is registered. A sample at edge N is visible in `slot_locked`/`char_index_o` after edge N (1-cycle latency).
- `recognize_done` rises at the same edge the last slot locks. `done_pulse` is high for exactly that cycle.
- Changing thresholds takes effect on the next sample. Already-locked slots are never re-evaluated.

## Structure
- Package `judge_pkg`:
  - slot state enum (IDLE, COUNT, LOCKED);
  - `EMPTY_IDX` function of IDX_W;
  - saturating increment helpers.
- Sub-module `judge_slot` holds one slot's state machine and registers. It is instantiated NUM_SLOTS times in a generate loop.
- Top level `judge_multi` does slot decode, output packing, and done/pulse generation.

## Test plan
- Thresholds: `max_diff`=30, `min_continue`=4, `min_counter`=10.
  - Slot 0 receives idx 5, diff 20, ×4 → locks after the 4th sample; result 5; forced=0.
- Slot 1 receives 5,4,3,5,5,4,5,5,5,4 at diff 20 → no run of 4; 10th sample locks by majority; result 5.
- Slot 2 receives 5,5,5 at diff 20, then 5 at diff 700 (rejected, run cleared), then 5 ×3 → not locked; `all_done` → result 5, forced=1. Any slot with no samples → EMPTY (0x3F), forced=1.
- Run all 7 slots to rule locks → `recognize_done` rises with the final lock, `done_pulse` is 1 cycle wide. Further samples change nothing.
- Edge cases:
  - `char_slot`=7 is ignored.
  - `min_continue`=0 locks on the first accepted sample.
  - `clear` in the same cycle as `all_done` → all slots IDLE, outputs at reset values.
- Saturation: `min_counter`=0 with 300 accepted samples alternating 1 and 2 → no lock and no counter wrap; `all_done` → result 1 or 2, matching the reference model.
